fetch_stage: RTL and testbench
==============================

# fetch_stage

Parametrised instruction-fetch stage for the pipelined MIPS datapath. It holds the program counter, drives the instruction-memory address, and registers the fetched instruction and PC+4 into the IF/ID boundary. Compared with the earlier fixed-width PC/IF-ID pair, it adds:

- synchronous reset to a configurable vector
- stall hold and flush-on-redirect
- a memory-ready bubble path
- misalignment detection
- two performance counters

It sits between the branch/jump resolution logic (redirect source), the hazard unit (stall source) and the decode stage.

## Interface
Parameters:
- ADDR_W, 32, PC / address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction injected on bubble/flush (sll $0,$0,0)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect  in  1  taken branch/jump: load redirect_target, flush IF/ID
- redirect_target  in  ADDR_W  new PC
- imem_addr  out  ADDR_W  instruction memory address (= pc_q, combinational)
- imem_rdata  in  INSTR_W  instruction word, same-cycle combinational read
- imem_ready  in  1  imem_rdata valid this cycle
- ifid_instr  out  INSTR_W  registered instruction to decode
- ifid_pc4  out  ADDR_W  registered PC+4 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0]
- fetch_cnt  out  CNT_W  instructions delivered to IF/ID
- bubble_cnt  out  CNT_W  bubbles inserted (not-ready or flush)

## Operation
Each rising edge is evaluated in the following priority order:
- **rst:**
  - pc_q=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0.
  - misalign_err=0, fetch_cnt=0, bubble_cnt=0.
- **redirect:**
  - pc_q = {redirect_target[ADDR_W-1:2],2'b00}.
  - IF/ID loaded with NOP_INSTR, ifid_valid=0, ifid_pc4=0.
  - bubble_cnt+1.
  - If redirect_target[1:0]≠0, set misalign_err.
  - Redirect overrides stall and imem_ready.
- **stall:** pc_q, IF/ID and counters all hold.
- **!imem_ready:**
  - pc_q holds.
  - IF/ID loaded with NOP_INSTR, ifid_valid=0.
  - bubble_cnt+1.
- **normal:**
  - pc_q = pc_q+4.
  - ifid_instr = imem_rdata, ifid_pc4 = pc_q+4, ifid_valid=1.
  - fetch_cnt+1.

Arithmetic and width rules:
- PC increment is modulo 2^ADDR_W. Fetching at 0xFFFF_FFFC gives next PC 0x0000_0000 with no flag.
- Counters saturate at all-ones; they do not wrap.
- misalign_err is cleared only by rst.

## Timing
- imem_addr follows pc_q with zero latency. Instruction at PC P appears on ifid_instr one edge after the cycle in which P is presented with imem_ready=1.
- Redirect latency:
  - Target is on imem_addr the cycle after redirect is sampled.
  - Its instruction reaches IF/ID one further edge later, with a one-bubble minimum penalty.
- If stall and redirect are both high, redirect wins. The hazard unit must not rely on stall to hold a wrong-path instruction.
- rst asserted mid-stall or mid-redirect takes effect on that edge; no partial update.
- Outputs carry reset values from the first edge with rst=1 until the first edge with rst=0 that updates them.

## Structure
- Shared package `mips_pkg`:
  - NOP_INSTR default
  - PC_INC (4)
  - instruction width constant
  - field slice constants (OP/RS/RT/RD/Shamt/Funct positions), reused by decode
- One natural sub-module, `ifid_reg`:
  - IF/ID register with load/hold/flush controls, parametrised on INSTR_W/ADDR_W
  - Reused style for ID/EX, EX/MEM, MEM/WB.
- PC logic, priority mux, misalignment detection and counters stay in fetch_stage.

## Test plan
- **Reset:**
  - Stimulus: RESET_PC=0x0040_0000, rst high 2 cycles, then release with imem_ready=1 and imem_rdata=0x2008_0005.
  - Required: imem_addr=0x0040_0000 during reset; after first edge, ifid_instr=0x2008_0005, ifid_pc4=0x0040_0004, ifid_valid=1, fetch_cnt=1.
- **Stall:**
  - Stimulus: stall high 3 cycles at PC 0x10.
  - Required: imem_addr stays 0x10; ifid_* and both counters unchanged; PC resumes 0x14 on the first edge after release.
- **Redirect with stall:**
  - Stimulus: redirect=1 with target 0x100 and stall=1 in the same cycle.
  - Required: next imem_addr=0x100, ifid_instr=NOP_INSTR, ifid_valid=0, bubble_cnt+1.
- **Misaligned redirect:**
  - Stimulus: redirect target 0x0000_0106.
  - Required: imem_addr=0x104, misalign_err=1, and it stays 1 until rst.
- **Memory not ready:**
  - Stimulus: imem_ready low 2 cycles at PC 0x20.
  - Required: 2 NOP bubbles with ifid_valid=0, bubble_cnt+2, PC held at 0x20; then ready high fetches 0x20.
- **Wrap and saturation:**
  - Stimulus: PC 0xFFFF_FFFC with ready high; separately CNT_W=4 run 20 fetches.
  - Required: next PC=0x0 and ifid_pc4=0x0; fetch_cnt saturates at 0xF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, PC step, the canonical NOP and
// instruction field positions used by fetch and decode.
package mips_pkg;

  localparam int unsigned MIPS_INSTR_W = 32;
  localparam int unsigned MIPS_ADDR_W  = 32;
  localparam int unsigned MIPS_PC_INC  = 4;

  // sll $0,$0,0
  localparam logic [MIPS_INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush clears everything, bubble injects a NOP
// while keeping the last PC+4, load captures a new instruction, else hold.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int unsigned INSTR_W = MIPS_INSTR_W,
  parameter int unsigned ADDR_W  = MIPS_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc4_d,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register with redirect/stall/not-ready priority,
// misalignment flag, saturating fetch/bubble counters and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = MIPS_ADDR_W,
  parameter int unsigned INSTR_W = MIPS_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_pc;
  logic              do_fetch;
  logic              do_bubble;
  logic              count_bubble;
  logic              misalign_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  assign pc_plus4    = pc_q + ADDR_W'(MIPS_PC_INC);
  assign redirect_pc = {redirect_target[ADDR_W-1:2], 2'b00};

  // Redirect beats stall beats memory-not-ready beats a normal fetch.
  always_comb begin
    pc_d      = pc_q;
    do_fetch  = 1'b0;
    do_bubble = 1'b0;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!stall) begin
      if (imem_ready) begin
        pc_d     = pc_plus4;
        do_fetch = 1'b1;
      end else begin
        do_bubble = 1'b1;
      end
    end
  end

  assign count_bubble = redirect | do_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (redirect && !is_word_aligned(redirect_target[1:0])) begin
        misalign_q <= 1'b1;
      end
      if (do_fetch && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (count_bubble && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;

  ifid_reg #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (do_fetch),
    .bubble (do_bubble),
    .flush  (redirect),
    .instr_d(imem_rdata),
    .pc4_d  (pc_plus4),
    .instr  (ifid_instr),
    .pc4    (ifid_pc4),
    .valid  (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level reference model and a
// second 4-bit-counter instance for saturation.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst, stall, redirect, imem_ready;
  logic [31:0] redirect_target, imem_rdata;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4, fetch_cnt, bubble_cnt;
  logic        ifid_valid, misalign_err;

  logic [31:0] s_imem_addr, s_ifid_instr, s_ifid_pc4;
  logic        s_ifid_valid, s_misalign_err;
  logic [3:0]  s_fetch_cnt, s_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  fetch_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_target(32'h0), .imem_addr(s_imem_addr),
    .imem_rdata(32'h1234_5678), .imem_ready(1'b1),
    .ifid_instr(s_ifid_instr), .ifid_pc4(s_ifid_pc4), .ifid_valid(s_ifid_valid),
    .misalign_err(s_misalign_err), .fetch_cnt(s_fetch_cnt), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic        m_known = 1'b0;
  logic        m_pc4_care;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;
  longint      m_fc, m_bc;
  int          s_cnt;

  function automatic longint sat_inc(input longint v, input longint max);
    return (v >= max) ? max : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1; m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'h0; m_pc4_care = 1'b1;
      m_valid = 1'b0; m_mis = 1'b0; m_fc = 0; m_bc = 0; s_cnt = 0;
    end else begin
      s_cnt = (s_cnt >= 15) ? 15 : s_cnt + 1;
      if (redirect) begin
        m_pc = redirect_target - (redirect_target % 4);
        m_instr = NOP; m_pc4 = 32'h0; m_pc4_care = 1'b1; m_valid = 1'b0;
        if (redirect_target % 4 != 0) m_mis = 1'b1;
        m_bc = sat_inc(m_bc, 64'hFFFF_FFFF);
      end else if (stall) begin
        m_pc = m_pc;
      end else if (!imem_ready) begin
        m_instr = NOP; m_valid = 1'b0; m_pc4_care = 1'b0;
        m_bc = sat_inc(m_bc, 64'hFFFF_FFFF);
      end else begin
        m_instr = imem_rdata;
        m_pc = m_pc + 32'd4;
        m_pc4 = m_pc; m_pc4_care = 1'b1; m_valid = 1'b1;
        m_fc = sat_inc(m_fc, 64'hFFFF_FFFF);
      end
    end
    #1;
    if (m_known) begin
      check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("ifid_instr", 64'(ifid_instr), 64'(m_instr));
      if (m_pc4_care) check("ifid_pc4", 64'(ifid_pc4), 64'(m_pc4));
      check("ifid_valid", 64'(ifid_valid), 64'(m_valid));
      check("misalign_err", 64'(misalign_err), 64'(m_mis));
      check("fetch_cnt", 64'(fetch_cnt), 64'(m_fc));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
      check("sat_fetch_cnt", 64'(s_fetch_cnt), 64'(s_cnt));
    end
  end

  task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] data);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_target = tgt;
    imem_ready = rdy; imem_rdata = data;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;

    step(1, 0, 0, 0, 1, 32'h2008_0005);
    step(1, 0, 0, 0, 1, 32'h2008_0005);
    check("lit_reset_addr", 64'(imem_addr), 64'h0040_0000);
    check("lit_reset_valid", 64'(ifid_valid), 64'h0);

    step(0, 0, 0, 0, 1, 32'h2008_0005);
    check("lit_first_instr", 64'(ifid_instr), 64'h2008_0005);
    check("lit_first_pc4", 64'(ifid_pc4), 64'h0040_0004);
    check("lit_first_valid", 64'(ifid_valid), 64'h1);
    check("lit_first_fcnt", 64'(fetch_cnt), 64'h1);

    step(0, 0, 1, 32'h10, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 32'h8C09_0010);
    check("lit_stall_addr", 64'(imem_addr), 64'h10);
    check("lit_stall_fcnt", 64'(fetch_cnt), 64'h1);
    step(0, 0, 0, 0, 1, 32'h8C09_0010);
    check("lit_resume_addr", 64'(imem_addr), 64'h14);
    check("lit_resume_pc4", 64'(ifid_pc4), 64'h14);

    step(0, 1, 1, 32'h100, 1, 32'h0123_4567);
    check("lit_rs_addr", 64'(imem_addr), 64'h100);
    check("lit_rs_instr", 64'(ifid_instr), 64'(NOP));
    check("lit_rs_valid", 64'(ifid_valid), 64'h0);
    check("lit_rs_bcnt", 64'(bubble_cnt), 64'h2);
    step(0, 0, 0, 0, 1, 32'hAAAA_0001);
    step(0, 0, 0, 0, 1, 32'hAAAA_0002);

    step(0, 0, 1, 32'h106, 1, 32'h0);
    check("lit_mis_addr", 64'(imem_addr), 64'h104);
    check("lit_mis_flag", 64'(misalign_err), 64'h1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'hBBBB_0000 + 32'(i));
    check("lit_mis_sticky", 64'(misalign_err), 64'h1);

    step(0, 0, 1, 32'h20, 1, 32'h0);
    step(0, 0, 0, 0, 0, 32'hCCCC_CCCC);
    step(0, 0, 0, 0, 0, 32'hCCCC_CCCC);
    check("lit_nr_addr", 64'(imem_addr), 64'h20);
    check("lit_nr_valid", 64'(ifid_valid), 64'h0);
    check("lit_nr_bcnt", 64'(bubble_cnt), 64'h6);
    step(0, 0, 0, 0, 1, 32'h2409_0020);
    check("lit_nr_fetch", 64'(ifid_instr), 64'h2409_0020);
    check("lit_nr_pc4", 64'(ifid_pc4), 64'h24);

    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h1111_2222);
    check("lit_wrap_addr", 64'(imem_addr), 64'h0);
    check("lit_wrap_pc4", 64'(ifid_pc4), 64'h0);
    check("lit_wrap_valid", 64'(ifid_valid), 64'h1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 32'h3333_0000 + 32'(i));
    check("lit_sat_fcnt", 64'(s_fetch_cnt), 64'hF);

    step(1, 1, 1, 32'h200, 1, 32'h0);
    check("lit_rst_addr", 64'(imem_addr), 64'h0040_0000);
    check("lit_rst_mis", 64'(misalign_err), 64'h0);
    check("lit_rst_bcnt", 64'(bubble_cnt), 64'h0);
    step(0, 0, 0, 0, 1, 32'h4444_0000);
    step(0, 0, 0, 0, 1, 32'h4444_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
